// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port one-hot codes, VC state encoding and
// the XY dimension-order routing function.
package noc_pkg;

  localparam int N_PORT     = 5;
  localparam int ADDR_MAX_W = 8;

  localparam logic [N_PORT-1:0] P_LOCAL = 5'b00001;
  localparam logic [N_PORT-1:0] P_NORTH = 5'b00010;
  localparam logic [N_PORT-1:0] P_EAST  = 5'b00100;
  localparam logic [N_PORT-1:0] P_SOUTH = 5'b01000;
  localparam logic [N_PORT-1:0] P_WEST  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE  = 2'd1,
    ACTIVE = 2'd2
  } vc_state_e;

  function automatic int tail_bit(input int data_width);
    return data_width - 1;
  endfunction

  // X is resolved before Y, which keeps XY routing deadlock-free on a mesh.
  function automatic logic [N_PORT-1:0] xy_route(
    input logic [ADDR_MAX_W-1:0] x_dst,
    input logic [ADDR_MAX_W-1:0] y_dst,
    input logic [ADDR_MAX_W-1:0] x_cur,
    input logic [ADDR_MAX_W-1:0] y_cur
  );
    logic [N_PORT-1:0] port;
    if (x_dst > x_cur)      port = P_EAST;
    else if (x_dst < x_cur) port = P_WEST;
    else if (y_dst > y_cur) port = P_NORTH;
    else if (y_dst < y_cur) port = P_SOUTH;
    else                    port = P_LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. Push while full and pop while empty are ignored.
module vc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: flit storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/input_port_vc.sv
// Router input port with N_VC virtual-channel FIFOs, per-VC wormhole XY route
// state and a registered single-flit output. Define INPUT_PORT_ERR_EN to add a sticky err output.
module input_port_vc
  import noc_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int N_ADD      = 2,
  parameter  int DEPTH      = 4,
  parameter  int N_VC       = 2,
  localparam int VC_W       = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ADD-1:0]         X_cur,
  input  logic [N_ADD-1:0]         Y_cur,
  input  logic                     val,
  input  logic [VC_W-1:0]          vc_in,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  output logic [N_VC-1:0]          ret,
  output logic [N_VC*N_PORT-1:0]   register,
  input  logic [N_VC-1:0]          grant,
  output logic [DATA_WIDTH-1:0]    Data_out,
  output logic [VC_W-1:0]          vc_out,
`ifdef INPUT_PORT_ERR_EN
  output logic                     valid_out,
  output logic                     err
`else
  output logic                     valid_out
`endif
);

  localparam int TAIL = tail_bit(DATA_WIDTH);

  logic [N_VC-1:0]       push, pop, full, empty, req;
  logic [DATA_WIDTH-1:0] head [N_VC];
  vc_state_e             state_q [N_VC], state_d [N_VC];
  logic [N_PORT-1:0]     route_q [N_VC], route_d [N_VC];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [VC_W-1:0]       vc_out_q, vc_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  lower_granted;

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    vc_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst),
      .push   (push[v]),
      .pop    (pop[v]),
      .data_in(Data_in),
      .full   (full[v]),
      .empty  (empty[v]),
      .head   (head[v])
    );
  end

  assign ret       = ~full;
  assign Data_out  = data_out_q;
  assign vc_out    = vc_out_q;
  assign valid_out = valid_out_q;

  // NOTE: lower_granted is a blocking running flag; its value carries between loop iterations.
  always_comb begin
    push          = '0;
    pop           = '0;
    req           = '0;
    register      = '0;
    lower_granted = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      push[v] = val && (vc_in == VC_W'(v)) && !full[v];
      req[v]  = (state_q[v] == ACTIVE) && !empty[v];
      register[v*N_PORT +: N_PORT] = req[v] ? route_q[v] : '0;
      // Only the lowest set grant bit may pop, and only from a requesting VC.
      pop[v]        = grant[v] && req[v] && !lower_granted;
      lower_granted = lower_granted || grant[v];
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    vc_out_d    = vc_out_q;
    valid_out_d = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      state_d[v] = state_q[v];
      route_d[v] = route_q[v];
      case (state_q[v])
        IDLE:   if (!empty[v]) state_d[v] = ROUTE;
        ROUTE: begin
          route_d[v] = xy_route(ADDR_MAX_W'(head[v][2*N_ADD-1:N_ADD]),
                                ADDR_MAX_W'(head[v][N_ADD-1:0]),
                                ADDR_MAX_W'(X_cur), ADDR_MAX_W'(Y_cur));
          state_d[v] = ACTIVE;
        end
        ACTIVE: if (pop[v] && head[v][TAIL]) begin
          state_d[v] = IDLE;
          route_d[v] = '0;
        end
        default: state_d[v] = IDLE;
      endcase
      if (pop[v]) begin
        data_out_d  = head[v];
        vc_out_d    = VC_W'(v);
        valid_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_VC; v++) begin
        state_q[v] <= IDLE;
        route_q[v] <= '0;
      end
      data_out_q  <= '0;
      vc_out_q    <= '0;
      valid_out_q <= 1'b0;
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        state_q[v] <= state_d[v];
        route_q[v] <= route_d[v];
      end
      data_out_q  <= data_out_d;
      vc_out_q    <= vc_out_d;
      valid_out_q <= valid_out_d;
    end
  end

`ifdef INPUT_PORT_ERR_EN
  logic err_q, err_d, err_event;

  assign err = err_q;

  always_comb begin
    err_event = (grant & (grant - N_VC'(1))) != '0;
    for (int v = 0; v < N_VC; v++) begin
      if (val && (vc_in == VC_W'(v)) && full[v]) err_event = 1'b1;
      if (grant[v] && !req[v])                  err_event = 1'b1;
    end
    err_d = err_q || err_event;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_input_port_vc.sv
// Directed bench for input_port_vc: per-VC reference queues feed an expected
// output queue when grants are issued; outputs are popped and compared.
module tb_input_port_vc;

  localparam int DW    = 8;
  localparam int NA    = 2;
  localparam int DEPTH = 4;
  localparam int NVC   = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          vc;
  } out_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NA-1:0]   X_cur, Y_cur;
  logic            val;
  logic            vc_in;
  logic [DW-1:0]   Data_in;
  logic [NVC-1:0]  ret;
  logic [NVC*5-1:0] register;
  logic [NVC-1:0]  grant;
  logic [DW-1:0]   Data_out;
  logic            vc_out;
  logic            valid_out;
`ifdef INPUT_PORT_ERR_EN
  logic            err;
`endif

  out_t          exp_q [$];
  logic [DW-1:0] model_q [NVC][$];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  input_port_vc #(.DATA_WIDTH(DW), .N_ADD(NA), .DEPTH(DEPTH), .N_VC(NVC)) dut (
    .clk      (clk),
    .rst      (rst),
    .X_cur    (X_cur),
    .Y_cur    (Y_cur),
    .val      (val),
    .vc_in    (vc_in),
    .Data_in  (Data_in),
    .ret      (ret),
    .register (register),
    .grant    (grant),
    .Data_out (Data_out),
    .vc_out   (vc_out),
`ifdef INPUT_PORT_ERR_EN
    .valid_out(valid_out),
    .err      (err)
`else
    .valid_out(valid_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the reference model, then check outputs #1 after the edge.
  task automatic step(input bit wr, input int wv, input logic [DW-1:0] d,
                      input logic [NVC-1:0] g, input bit exp_pop);
    out_t e;
    int   gv;
    bit   accept;
    val     = wr;
    vc_in   = 1'(wv);
    Data_in = d;
    grant   = g;
    accept  = wr && (model_q[wv].size() < DEPTH);
    if (exp_pop) begin
      gv     = g[0] ? 0 : 1;
      e.data = model_q[gv].pop_front();
      e.vc   = 1'(gv);
      exp_q.push_back(e);
    end
    if (accept) model_q[wv].push_back(d);
    @(posedge clk);
    #1;
    val   = 1'b0;
    grant = '0;
    check("valid_out", 32'(valid_out), 32'(exp_pop));
    if (valid_out === 1'b1) begin
      check("pending_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("Data_out", 32'(Data_out), 32'(e.data));
        check("vc_out", 32'(vc_out), 32'(e.vc));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] flits [4];
    logic [4:0]    routes [4];
    rst     = 1'b0;
    X_cur   = 2'd1;
    Y_cur   = 2'd1;
    val     = 1'b0;
    vc_in   = 1'b0;
    Data_in = '0;
    grant   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ret", 32'(ret), 32'h3);
    check("reset_register", 32'(register), 32'h0);
    check("reset_valid_out", 32'(valid_out), 32'h0);
    check("reset_Data_out", 32'(Data_out), 32'h0);
    check("reset_vc_out", 32'(vc_out), 32'h0);
`ifdef INPUT_PORT_ERR_EN
    check("reset_err", 32'(err), 32'h0);
`endif
    rst = 1'b1;

    // Single-flit packet to (3,1) on VC0: EAST request from T+2, one-cycle grant latency.
    step(1'b1, 0, 8'h8D, '0, 1'b0);
    check("t1_req_idle", 32'(register), 32'h0);
    idle(1);
    check("t1_req_route", 32'(register), 32'h0);
    idle(1);
    check("t1_req_east", 32'(register), 32'h004);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    check("t1_req_cleared", 32'(register), 32'h0);
    idle(1);
    check("t1_data_hold", 32'(Data_out), 32'h8D);

    // Four single-flit packets on VC1 exercising LOCAL, SOUTH, WEST, NORTH.
    flits  = '{8'h85, 8'h84, 8'h82, 8'h87};
    routes = '{5'b00001, 5'b01000, 5'b10000, 5'b00010};
    for (int i = 0; i < 4; i++) step(1'b1, 1, flits[i], '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t2_route", 32'(register), 32'({routes[i], 5'b00000}));
      step(1'b0, 0, '0, 2'b10, 1'b1);
      idle(2);
    end
    check("t2_all_idle", 32'(register), 32'h0);

    // Fill VC0, drop the fifth flit, VC1 still accepts.
    flits = '{8'h0D, 8'h11, 8'h22, 8'hB3};
    for (int i = 0; i < 4; i++) step(1'b1, 0, flits[i], '0, 1'b0);
    check("t3_ret_full", 32'(ret), 32'h2);
    step(1'b1, 0, 8'h44, '0, 1'b0);
    check("t3_ret_drop", 32'(ret), 32'h2);
    step(1'b1, 1, 8'h85, '0, 1'b0);
    check("t3_ret_vc1", 32'(ret), 32'h2);
    idle(2);
    check("t3_both_req", 32'(register), 32'h024);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    check("t3_ret_after_pop", 32'(ret), 32'h3);
    step(1'b0, 0, '0, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t3_vc0_route_held", 32'(register), 32'h004);
      step(1'b0, 0, '0, 2'b01, 1'b1);
    end
    idle(2);
    check("t3_idle", 32'(register), 32'h0);

    // Interleaved VC0 3-flit packet (EAST) and VC1 1-flit packet (NORTH).
    step(1'b1, 0, 8'h0D, '0, 1'b0);
    step(1'b1, 1, 8'h87, '0, 1'b0);
    idle(2);
    check("t4_both_req", 32'(register), 32'h044);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    check("t4_vc0_drained", 32'(register), 32'h040);
    step(1'b0, 0, '0, 2'b10, 1'b1);
    check("t4_vc1_done", 32'(register), 32'h0);
    step(1'b0, 0, '0, 2'b01, 1'b0);
    step(1'b1, 0, 8'h55, '0, 1'b0);
    check("t4_route_kept_body", 32'(register), 32'h004);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    step(1'b1, 0, 8'h9F, '0, 1'b0);
    check("t4_route_kept_tail", 32'(register), 32'h004);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    idle(2);
    check("t4_idle", 32'(register), 32'h0);

    // Full VC, push blocked while full, push+pop together, then pointer wrap.
    flits = '{8'h0D, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++) step(1'b1, 0, flits[i], '0, 1'b0);
    check("t5_ret_full", 32'(ret), 32'h2);
    step(1'b1, 0, 8'h04, 2'b01, 1'b1);
    check("t5_ret_pop_blocked_push", 32'(ret), 32'h3);
    step(1'b1, 0, 8'h05, 2'b01, 1'b1);
    check("t5_ret_push_pop", 32'(ret), 32'h3);
    step(1'b1, 0, 8'h06, '0, 1'b0);
    check("t5_ret_refull", 32'(ret), 32'h2);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 0, (i == 9) ? 8'hA9 : 8'(8'h20 + i), 2'b01, 1'b1);
      check("t5_ret_stream", 32'(ret), 32'h3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 2'b01, 1'b1);
    check("t5_drained_ret", 32'(ret), 32'h3);
    idle(2);
    check("t5_idle", 32'(register), 32'h0);

    // Asynchronous reset in the middle of a VC0 packet.
    step(1'b1, 0, 8'h0D, '0, 1'b0);
    step(1'b1, 0, 8'h11, '0, 1'b0);
    step(1'b1, 0, 8'h12, '0, 1'b0);
    check("t6_pre_req", 32'(register), 32'h004);
    step(1'b0, 0, '0, 2'b01, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_ret", 32'(ret), 32'h3);
    check("t6_rst_register", 32'(register), 32'h0);
    check("t6_rst_valid_out", 32'(valid_out), 32'h0);
    check("t6_rst_Data_out", 32'(Data_out), 32'h0);
    check("t6_rst_vc_out", 32'(vc_out), 32'h0);
`ifdef INPUT_PORT_ERR_EN
    check("t6_rst_err", 32'(err), 32'h0);
`endif
    for (int v = 0; v < NVC; v++) model_q[v].delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1, 8'h85, '0, 1'b0);
    idle(2);
    check("t6_fresh_local", 32'(register), 32'h020);
    step(1'b0, 0, '0, 2'b10, 1'b1);
    check("t6_fresh_done", 32'(register), 32'h0);
    step(1'b0, 0, '0, 2'b11, 1'b0);
`ifdef INPUT_PORT_ERR_EN
    check("t6_err_multi_grant", 32'(err), 32'h1);
`endif
    idle(1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
